// File: rtl/max_finder.sv
// rtl/max_finder.sv - serial signed argmax over N snapshotted output-neuron values
// One compare per cycle after the enMax capture; result published with a one-cycle done pulse.
module max_finder #(
    parameter int N  = 10,
    parameter int W  = 8,
    parameter int IW = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            enMax,
    input  logic [N*W-1:0]  outs_flat,
    output logic [IW-1:0]   max_index,
    output logic [W-1:0]    max_value,
    output logic            busy,
    output logic            done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic signed [W-1:0] v_q [N];
    logic signed [W-1:0] v_d [N];
    logic signed [W-1:0] best_val_q, best_val_d;
    logic [IW-1:0]       best_idx_q, best_idx_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [IW-1:0]       max_index_q, max_index_d;
    logic [W-1:0]        max_value_q, max_value_d;

    logic signed [W-1:0] cur_val;
    logic                last_cmp;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (enMax) state_d = ST_SCAN;
            ST_SCAN: if (last_cmp) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == ST_SCAN);
        done = (state_q == ST_DONE);
    end

    // Explicit select avoids indexing past N-1 when IW can encode more than N values.
    always_comb begin
        cur_val = '0;
        for (int i = 0; i < N; i++) begin
            if (idx_q == IW'(i)) cur_val = v_q[i];
        end
    end

    assign last_cmp = (idx_q == IW'(N - 1));

    always_comb begin
        v_d         = v_q;
        best_val_d  = best_val_q;
        best_idx_d  = best_idx_q;
        idx_d       = idx_q;
        max_index_d = max_index_q;
        max_value_d = max_value_q;
        case (state_q)
            ST_IDLE: begin
                if (enMax) begin
                    for (int i = 0; i < N; i++) begin
                        v_d[i] = outs_flat[i*W +: W];
                    end
                    best_val_d = outs_flat[W-1:0];
                    best_idx_d = '0;
                    idx_d      = IW'(1);
                end
            end
            ST_SCAN: begin
                // Strict compare keeps the lowest index among equal maxima.
                if (cur_val > best_val_q) begin
                    best_val_d = cur_val;
                    best_idx_d = idx_q;
                end
                if (last_cmp) begin
                    max_value_d = best_val_d;
                    max_index_d = best_idx_d;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                v_q[i] <= '0;
            end
            best_val_q  <= '0;
            best_idx_q  <= '0;
            idx_q       <= '0;
            max_index_q <= '0;
            max_value_q <= '0;
        end else begin
            v_q         <= v_d;
            best_val_q  <= best_val_d;
            best_idx_q  <= best_idx_d;
            idx_q       <= idx_d;
            max_index_q <= max_index_d;
            max_value_q <= max_value_d;
        end
    end

    assign max_index = max_index_q;
    assign max_value = max_value_q;

endmodule

// File: tb/tb_max_finder.sv
// tb/tb_max_finder.sv - table-driven and scoreboard bench for max_finder
module tb_max_finder;

    localparam int N  = 10;
    localparam int W  = 8;
    localparam int IW = 4;

    logic            clk;
    logic            rst_n;
    logic            enMax;
    logic [N*W-1:0]  outs_flat;
    logic [IW-1:0]   max_index;
    logic [W-1:0]    max_value;
    logic            busy;
    logic            done;

    max_finder #(.N(N), .W(W), .IW(IW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enMax     (enMax),
        .outs_flat (outs_flat),
        .max_index (max_index),
        .max_value (max_value),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [N*W-1:0] outs;
        int             exp_idx;
        int             exp_val;
    } vec_t;

    typedef struct {
        int idx;
        int val;
    } res_t;

    vec_t tbl [5];
    res_t sb [$];

    int tests;
    int fails;
    int cyc;
    int scan_start;
    int exp_idx;
    int exp_val;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %0d, required %0d", name, cyc, act, exp);
        end
    endtask

    function automatic logic [N*W-1:0] pack(input int a [N]);
        logic [N*W-1:0] r;
        int x;
        r = '0;
        for (int i = 0; i < N; i++) begin
            x = a[i];
            r[i*W +: W] = x[W-1:0];
        end
        return r;
    endfunction

    function automatic logic [N*W-1:0] fill(input int val);
        int a [N];
        for (int i = 0; i < N; i++) a[i] = val;
        return pack(a);
    endfunction

    task automatic observe();
        logic exp_busy;
        logic exp_done;
        res_t r;
        exp_busy = (scan_start >= 0) && (cyc >= scan_start + 1) && (cyc <= scan_start + N - 1);
        exp_done = (scan_start >= 0) && (cyc == scan_start + N);
        if (exp_done) begin
            if (sb.size() == 0) begin
                chk("scoreboard_empty", 0, 1);
            end else begin
                r = sb.pop_front();
                exp_idx = r.idx;
                exp_val = r.val;
            end
        end
        chk("busy", int'(busy), int'(exp_busy));
        chk("done", int'(done), int'(exp_done));
        chk("max_index", int'(max_index), exp_idx);
        chk("max_value", int'($signed(max_value)), exp_val);
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        observe();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Drives a one-cycle enMax; the bench decides by itself whether the DUT is idle.
    task automatic strobe(input logic [N*W-1:0] v, input int e_idx, input int e_val);
        res_t r;
        outs_flat = v;
        enMax = 1'b1;
        if (rst_n && ((scan_start < 0) || (cyc > scan_start + N))) begin
            scan_start = cyc;
            r.idx = e_idx;
            r.val = e_val;
            sb.push_back(r);
        end
        tick();
        enMax = 1'b0;
    endtask

    task automatic apply_reset(input int n);
        rst_n = 1'b0;
        scan_start = -1;
        sb.delete();
        exp_idx = 0;
        exp_val = 0;
        idle(n);
        rst_n = 1'b1;
    endtask

    initial begin
        int tv [5][N];
        logic [N*W-1:0] basic;
        int c0;

        tests = 0;
        fails = 0;
        cyc = 0;
        scan_start = -1;
        exp_idx = 0;
        exp_val = 0;
        enMax = 1'b0;
        outs_flat = '0;
        rst_n = 1'b0;

        tv[0] = '{3, -7, 12, 5, 40, -1, 0, 39, 8, 2};
        tv[1] = '{-128, -128, -128, -5, -128, -128, -128, -128, -5, -128};
        tv[2] = '{-128, -128, -128, -128, -128, -128, -128, -128, -128, 127};
        tv[3] = '{127, 127, 127, 127, 127, 127, 127, 127, 127, 127};
        tv[4] = '{-1, -2, -3, -4, -5, -6, -7, -8, -9, -10};
        tbl[0] = '{pack(tv[0]), 4, 40};
        tbl[1] = '{pack(tv[1]), 3, -5};
        tbl[2] = '{pack(tv[2]), 9, 127};
        tbl[3] = '{pack(tv[3]), 0, 127};
        tbl[4] = '{pack(tv[4]), 0, -1};
        basic = tbl[0].outs;

        apply_reset(2);
        idle(20);

        // Back-to-back scans: each strobe lands in the first IDLE cycle after DONE.
        for (int i = 0; i < 5; i++) begin
            strobe(tbl[i].outs, tbl[i].exp_idx, tbl[i].exp_val);
            idle(N);
        end
        idle(3);

        // Input isolation and a strobe lost during SCAN.
        c0 = cyc;
        strobe(basic, 4, 40);
        idle(2);
        strobe(fill(100), 0, 0);
        idle(c0 + 11 - cyc);
        chk("restart_cycle", cyc - c0, 11);
        strobe(fill(100), 0, 100);
        idle(N + 2);

        // Reset mid-scan, then restart on the first edge after release.
        c0 = cyc;
        strobe(basic, 4, 40);
        idle(c0 + 5 - cyc);
        apply_reset(1);
        strobe(tbl[1].outs, 3, -5);
        idle(N + 1);

        // Reset and enMax on the same edge: no capture.
        enMax = 1'b1;
        outs_flat = tbl[2].outs;
        apply_reset(1);
        enMax = 1'b0;
        idle(N + 3);

        chk("scoreboard_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/max_finder.md
# max_finder

Output-layer argmax unit for the neural-network datapath. It sits directly downstream of the circuit controller and the output-layer neuron registers. On the controller's one-cycle `enMax` strobe it snapshots all output-neuron values. It then scans them serially, one comparison per cycle, and reports the winning class index and its value with a one-cycle `done` pulse.

## Interface
- `N`, 10, number of output neurons / classes (N ≥ 2)
- `W`, 8, width of each neuron output; values are two's-complement signed
- `IW`, $clog2(N) (4 for N=10), width of the class index
- `clk`  in  1  system clock; all state changes on the rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `enMax`  in  1  start strobe from the circuit controller; sampled only in IDLE
- `outs_flat`  in  N*W  neuron outputs; neuron i occupies bits [i*W +: W]
- `max_index`  out  IW  index of the largest value (0..N-1)
- `max_value`  out  W  signed value at `max_index`
- `busy`  out  1  high while a scan is in progress (SCAN state)
- `done`  out  1  one-cycle pulse when `max_index`/`max_value` are updated

## Operation
- States:
  - IDLE: waits for `enMax`.
  - SCAN: comparing.
  - DONE: result published.
- IDLE, `enMax`=1:
  - Copy all N fields of `outs_flat` into internal snapshot registers `v[0..N-1]`.
  - Set `best_val`=v[0], `best_idx`=0, `idx`=1.
  - Go to SCAN.
- IDLE, `enMax`=0: stay in IDLE; snapshot, best and output registers hold.
- SCAN, each edge:
  - If `v[idx]` > `best_val` (signed, strict), load `best_val`=v[idx] and `best_idx`=idx; otherwise hold.
  - If `idx`==N-1: copy the final best pair (including this cycle's compare) into `max_value`/`max_index` and go to DONE.
  - Otherwise increment `idx`.
- DONE: `done`=1 for exactly this cycle; unconditionally return to IDLE.
- Ties: strict comparison, so the lowest index among equal maxima wins.
- Input isolation: `outs_flat` is ignored after the capture edge. The upstream may reload its registers during SCAN without affecting the result.
- `enMax` is ignored in SCAN and DONE. It is not queued, and a strobe arriving then is lost.
- `max_index`/`max_value` change only on the SCAN→DONE edge. They hold their value through IDLE until the next completed scan.
- `idx` never wraps: it runs 1..N-1 and is reinitialised on every capture.
- Arithmetic: comparison only, no overflow possible. `max_value` is the unaltered W-bit snapshot value.

## Timing
- Reset (`rst_n`=0 at a rising edge):
  - State goes to IDLE.
  - `max_index`=0, `max_value`=0, `busy`=0, `done`=0.
  - Snapshot and best registers are cleared.
- Reset mid-scan: aborts the scan. No `done` pulse, outputs forced to 0, and `enMax` is accepted again on the first edge with `rst_n`=1.
- `rst_n`=0 and `enMax`=1 on the same edge: reset wins and no capture occurs.
- Latency, with `enMax` high in cycle 0:
  - SCAN occupies cycles 1..N-1 (N-1 compares); `busy`=1 in exactly these cycles.
  - DONE occurs in cycle N: `done`=1 and new outputs are visible.
  - For N=10, `done` is high in cycle 10.
- Earliest restart: `enMax` in cycle N+1 (first IDLE cycle after DONE) is accepted. The back-to-back throughput is one result per N+1 cycles.
- `done` and `busy` are registered state decodes with no combinational path from `enMax`.

## Test plan
- Reset then idle:
  - Stimulus: hold `rst_n`=0 for 2 cycles, release, keep `enMax`=0 for 20 cycles.
  - Required: `max_index`=0, `max_value`=0, `busy`=0, `done`=0 throughout.
- Basic argmax, N=10:
  - Stimulus: outputs {3,-7,12,5,40,-1,0,39,8,2} (index 0 first), one-cycle `enMax` in cycle 0.
  - Required: `busy` high in cycles 1–9, `done` high only in cycle 10, `max_index`=4, `max_value`=40.
- Negative values and ties:
  - Stimulus: all outputs -128 except indices 3 and 8 = -5.
  - Required: `max_index`=3, `max_value`=-5 (0xFB). The signed compare must pass; index 8 must not win the tie.
- Extremes:
  - Stimulus A: index 9 = 127, all others -128. Required: `max_index`=9, proving the last compare is included.
  - Stimulus B: index 0 = 127, all others 127. Required: `max_index`=0.
- Isolation and ignored strobe:
  - Stimulus: after capture of the basic vector, in cycle 3 change `outs_flat` to all 100 and pulse `enMax`.
  - Required: result is still index 4 / 40 in cycle 10, and only one `done` pulse occurs.
  - Stimulus: then pulse `enMax` in cycle 11 with the all-100 input.
  - Required: `done` in cycle 21 with index 0 / 100.
- Reset mid-scan:
  - Stimulus: start a scan, drop `rst_n` in cycle 5 for one cycle.
  - Required: no `done` pulse, outputs 0, `busy`=0.
  - Stimulus: then restart with `enMax` in the first cycle after reset release.
  - Required: `done` exactly N cycles after that strobe, with the correct result.
